// File: rtl/mem_pkg.sv
// Shared packet-memory definitions.
//   ADDR_W      - block index width
//   NUM_BLOCKS  - number of managed packet-memory blocks
//   block_idx_t - block index type
//   fl_cnt_t    - free-block count type (one bit wider than an index)
//   fl_state_e  - free-list controller states
package mem_pkg;

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned NUM_BLOCKS = 8;

  typedef logic [ADDR_W-1:0] block_idx_t;
  typedef logic [ADDR_W:0]   fl_cnt_t;

  typedef enum logic {
    FL_INIT,
    FL_READY
  } fl_state_e;

endpackage

// File: rtl/fl_ptr_ctr.sv
// Wrapping pointer for the free-list circular FIFO.
// Counts 0 .. NUM_BLOCKS-1 and wraps back to 0, so NUM_BLOCKS need not be a
// power of two.
//   clk, rst_n - clock, asynchronous active-low reset (pointer clears to 0)
//   advance    - step the pointer by one on the next rising edge
//   ptr        - current pointer value
module fl_ptr_ctr #(
  parameter int unsigned NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int unsigned ADDR_W     = mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BLOCKS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/free_list.sv
// Free packet-memory block pool.
// Circular FIFO of free block indices. After reset it fills itself with
// 0 .. NUM_BLOCKS-1 (INIT), then serves one allocation per cycle and accepts
// returned blocks (READY).
//   clk, rst_n            - clock, asynchronous active-low reset
//   fl_alloc_req_i        - allocation request from the arbiter
//   fl_alloc_gnt_o        - allocation granted this cycle (combinational)
//   fl_alloc_block_idx_o  - head-of-pool index, driven in READY even without a grant
//   fl_free_req_i         - block return strobe
//   fl_free_block_idx_i   - returned block index
//   fl_free_cnt_o         - number of free blocks held (registered)
//   fl_ready_o            - self-initialisation complete
//   fl_almost_empty_o     - free count at or below LOW_WM while ready
//   fl_err_o              - sticky: double free, out-of-range free, or free during INIT
module free_list #(
  parameter int unsigned NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
  parameter int unsigned LOW_WM     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fl_alloc_req_i,
  output logic              fl_alloc_gnt_o,
  output logic [ADDR_W-1:0] fl_alloc_block_idx_o,
  input  logic              fl_free_req_i,
  input  logic [ADDR_W-1:0] fl_free_block_idx_i,
  output logic [ADDR_W:0]   fl_free_cnt_o,
  output logic              fl_ready_o,
  output logic              fl_almost_empty_o,
  output logic              fl_err_o
);

  import mem_pkg::*;

  // Storage spans the full index space so any ADDR_W-wide pointer indexes it
  // cleanly; entries at or above NUM_BLOCKS are never written or read.
  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(NUM_BLOCKS);
  localparam logic [ADDR_W:0]   LOW_CNT  = (ADDR_W + 1)'(LOW_WM);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BLOCKS - 1);

  fl_state_e         state_q;
  fl_state_e         state_d;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_data;
  logic [ADDR_W-1:0] init_cnt_q;
  logic [ADDR_W:0]   count_q;
  logic              push;
  logic              pop;
  logic              err_set;
  logic              init_step;
  logic              idx_bad;
  logic              ready;

  fl_ptr_ctr #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .ADDR_W     (ADDR_W)
  ) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (pop),
    .ptr     (rd_ptr)
  );

  fl_ptr_ctr #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .ADDR_W     (ADDR_W)
  ) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (push),
    .ptr     (wr_ptr)
  );

  assign idx_bad = ({1'b0, fl_free_block_idx_i} >= FULL_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FL_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pop       = 1'b0;
    wr_data   = init_cnt_q;
    err_set   = 1'b0;
    init_step = 1'b0;
    unique case (state_q)
      FL_INIT: begin
        push      = 1'b1;
        init_step = 1'b1;
        err_set   = fl_free_req_i;
        if (init_cnt_q == LAST_IDX) begin
          state_d = FL_READY;
        end
      end
      FL_READY: begin
        pop     = fl_alloc_req_i & (count_q != '0);
        wr_data = fl_free_block_idx_i;
        if (fl_free_req_i) begin
          // A grant in the same cycle frees a slot, so a full pool only
          // rejects the return when nothing is being popped.
          if (idx_bad || ((count_q == FULL_CNT) && !pop)) begin
            err_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_d = FL_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      init_cnt_q <= '0;
      fl_err_o   <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (init_step) begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end
      if (err_set) begin
        fl_err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign ready                = (state_q == FL_READY);
  assign fl_ready_o           = ready;
  assign fl_alloc_gnt_o       = pop;
  assign fl_alloc_block_idx_o = ready ? mem[rd_ptr] : '0;
  assign fl_free_cnt_o        = count_q;
  assign fl_almost_empty_o    = ready & (count_q <= LOW_CNT);

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, free_req;
  logic [2:0] free_idx;
  logic       gnt, ready, ae, err;
  logic [2:0] idx;
  logic [3:0] cnt;

  logic       req2, free_req2;
  logic [3:0] free_idx2;
  logic       gnt2, ready2, ae2, err2;
  logic [3:0] idx2;
  logic [4:0] cnt2;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [2:0]  exp_q[$];

  always #5 clk = ~clk;

  free_list #(
    .NUM_BLOCKS (8),
    .ADDR_W     (3),
    .LOW_WM     (2)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .fl_alloc_req_i       (req),
    .fl_alloc_gnt_o       (gnt),
    .fl_alloc_block_idx_o (idx),
    .fl_free_req_i        (free_req),
    .fl_free_block_idx_i  (free_idx),
    .fl_free_cnt_o        (cnt),
    .fl_ready_o           (ready),
    .fl_almost_empty_o    (ae),
    .fl_err_o             (err)
  );

  free_list #(
    .NUM_BLOCKS (8),
    .ADDR_W     (4),
    .LOW_WM     (2)
  ) dut_wide (
    .clk                  (clk),
    .rst_n                (rst_n),
    .fl_alloc_req_i       (req2),
    .fl_alloc_gnt_o       (gnt2),
    .fl_alloc_block_idx_o (idx2),
    .fl_free_req_i        (free_req2),
    .fl_free_block_idx_i  (free_idx2),
    .fl_free_cnt_o        (cnt2),
    .fl_ready_o           (ready2),
    .fl_almost_empty_o    (ae2),
    .fl_err_o             (err2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every grant must match the next expected index.
  always @(negedge clk) begin : monitor
    logic [2:0] e;
    if (rst_n === 1'b1 && gnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant actual=idx %0d required=no grant at %0t", idx, $time);
      end else begin
        e = exp_q.pop_front();
        chk("grant_idx", int'(idx), int'(e));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0; req = 1'b1; free_req = 1'b0; free_idx = '0;
    req2 = 1'b0; free_req2 = 1'b0; free_idx2 = '0;
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    cyc(); cyc();
    mid();
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ae", int'(ae), 0);

    // Init with req held high: no grants until ready.
    cyc(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      mid();
      chk("init_ready", int'(ready), 0);
      chk("init_cnt", int'(cnt), k);
      chk("init_gnt", int'(gnt), 0);
    end

    // Drain 0..7 on consecutive cycles, then empty.
    for (int j = 0; j <= 8; j++) begin
      cyc(); mid();
      chk("drain_ready", int'(ready), 1);
      chk("drain_cnt", int'(cnt), 8 - j);
      chk("drain_ae", int'(ae), ((8 - j) <= 2) ? 1 : 0);
      if (j == 8) chk("empty_gnt", int'(gnt), 0);
    end

    // Return 5 then 2, reuse in FIFO order.
    cyc(); req = 1'b0; free_req = 1'b1; free_idx = 3'd5; mid(); chk("reuse_cnt0", int'(cnt), 0);
    cyc(); free_idx = 3'd2; mid(); chk("reuse_cnt1", int'(cnt), 1);
    cyc(); free_req = 1'b0; req = 1'b1; exp_q.push_back(3'd5); mid(); chk("reuse_cnt2", int'(cnt), 2);
    cyc(); exp_q.push_back(3'd2); mid(); chk("reuse_cnt3", int'(cnt), 1);

    // Empty pool: req + free together -> no grant, free accepted.
    cyc(); free_req = 1'b1; free_idx = 3'd3; mid();
    chk("sim_empty_gnt", int'(gnt), 0);
    chk("sim_empty_cnt", int'(cnt), 0);
    cyc(); free_req = 1'b0; exp_q.push_back(3'd3); mid(); chk("sim_empty_cnt1", int'(cnt), 1);

    // Build count 4, then req + free together.
    cyc(); req = 1'b0; free_req = 1'b1; free_idx = 3'd1; mid(); chk("fill_cnt0", int'(cnt), 0);
    cyc(); free_idx = 3'd4; mid(); chk("fill_cnt1", int'(cnt), 1);
    cyc(); free_idx = 3'd6; mid(); chk("fill_cnt2", int'(cnt), 2);
    cyc(); free_idx = 3'd0; mid(); chk("fill_cnt3", int'(cnt), 3);
    cyc(); req = 1'b1; free_idx = 3'd7; exp_q.push_back(3'd1); mid();
    chk("sim_mid_cnt_before", int'(cnt), 4);
    chk("sim_mid_gnt", int'(gnt), 1);
    cyc(); req = 1'b0; free_idx = 3'd2; mid(); chk("sim_mid_cnt", int'(cnt), 4);
    cyc(); free_idx = 3'd3; mid(); chk("fill_cnt5", int'(cnt), 5);
    cyc(); free_idx = 3'd5; mid(); chk("fill_cnt6", int'(cnt), 6);
    cyc(); free_idx = 3'd1; mid(); chk("fill_cnt7", int'(cnt), 7);

    // Double free at full count.
    cyc(); free_idx = 3'd0; mid();
    chk("full_cnt", int'(cnt), 8);
    chk("full_err_before", int'(err), 0);
    chk("full_ae", int'(ae), 0);
    cyc(); free_req = 1'b0; mid();
    chk("dbl_free_err", int'(err), 1);
    chk("dbl_free_cnt", int'(cnt), 8);

    // Full pool: grant makes room for a same-cycle free. Pool: 4,6,0,7,2,3,5,1.
    cyc(); req = 1'b1; free_req = 1'b1; free_idx = 3'd4; exp_q.push_back(3'd4); mid();
    chk("full_swap_gnt", int'(gnt), 1);
    cyc(); free_req = 1'b0; exp_q.push_back(3'd6); mid();
    chk("full_swap_cnt", int'(cnt), 8);
    chk("err_sticky", int'(err), 1);
    cyc(); exp_q.push_back(3'd0); mid(); chk("alloc_cnt7", int'(cnt), 7);
    cyc(); exp_q.push_back(3'd7); mid(); chk("alloc_cnt6", int'(cnt), 6);
    cyc(); req = 1'b0; mid(); chk("alloc_cnt5", int'(cnt), 5);

    // Asynchronous reset mid-cycle.
    #2; rst_n = 1'b0; req = 1'b1; #1;
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_ready", int'(ready), 0);
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_ae", int'(ae), 0);
    chk("arst_idx", int'(idx), 0);
    cyc(); req = 1'b0;
    cyc(); rst_n = 1'b1; free_req = 1'b1; free_idx = 3'd0; mid();
    chk("init_free_err_before", int'(err), 0);
    cyc(); free_req = 1'b0; mid();
    chk("init_free_err", int'(err), 1);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      cyc(); mid(); n++;
    end
    chk("reinit_ready", int'(ready), 1);
    chk("reinit_cnt", int'(cnt), 8);
    for (int i = 0; i < 3; i++) begin
      cyc(); req = 1'b1; exp_q.push_back(3'(i)); mid();
      chk("regrant_cnt", int'(cnt), 8 - i);
    end
    cyc(); req = 1'b0; mid(); chk("regrant_cnt_end", int'(cnt), 5);

    // Wide build: out-of-range index is dropped and flagged.
    chk("wide_ready", int'(ready2), 1);
    chk("wide_err0", int'(err2), 0);
    chk("wide_cnt8", int'(cnt2), 8);
    cyc(); req2 = 1'b1; mid();
    chk("wide_gnt", int'(gnt2), 1);
    chk("wide_idx", int'(idx2), 0);
    cyc(); req2 = 1'b0; free_req2 = 1'b1; free_idx2 = 4'd9; mid();
    chk("wide_cnt7", int'(cnt2), 7);
    chk("wide_err_before", int'(err2), 0);
    cyc(); free_req2 = 1'b0; mid();
    chk("range_err", int'(err2), 1);
    chk("range_cnt", int'(cnt2), 7);

    cyc(); cyc(); mid();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
